rf_pulse_tx: RTL

//  Synthesizable pulse-position transmitter that generates the rfin stream consumed by the
//  APB/SPI receive path. Sends a frame of PREAMBLE_BITS '1' symbols, then DATA_BITS of the

---
 rtl/rf_pulse_tx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rf_pulse_tx.sv
// Pulse-position transmitter: a preamble of '1' symbols, then the latched word MSB first,
// one fixed-length slot per symbol, with a '1' sent as a single pulse inside its slot.
module rf_pulse_tx #(
  parameter int unsigned SLOT_CYCLES   = 10000,
  parameter int unsigned POS_CYCLES    = 5000,
  parameter int unsigned HIGH_CYCLES   = 1,
  parameter int unsigned PREAMBLE_BITS = 8,
  parameter int unsigned DATA_BITS     = 64
) (
  input  logic                 i_PCLK,
  input  logic                 i_PRESETn,
  input  logic                 i_START,
  input  logic                 i_ABORT,
  input  logic [DATA_BITS-1:0] i_DATA,
  output logic                 o_RFIN,
  output logic                 o_BUSY,
  output logic                 o_DONE,
  output logic [6:0]           o_SYM_IDX
);

  localparam int unsigned CNT_W      = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned FRAME_SYMS = PREAMBLE_BITS + DATA_BITS;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [6:0] PRE_LAST   = 7'(PREAMBLE_BITS - 1);
  localparam logic [6:0] FRAME_LAST = 7'(FRAME_SYMS - 1);

  // The pulse must fit inside its own slot and be at least one cycle wide.
  if (HIGH_CYCLES == 0 || POS_CYCLES + HIGH_CYCLES > SLOT_CYCLES) begin : g_bad_timing
    $error("rf_pulse_tx: pulse window does not fit inside the slot");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     slot_cnt;
  logic [CNT_W-1:0]     slot_cnt_nxt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [6:0]           sym_idx_nxt;
  logic                 rfin_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic                 slot_end;
  logic                 in_window;
  logic                 sym_val;
  logic                 sending;

  // Next-state, slot/symbol bookkeeping and next values of the registered outputs.
  always_comb begin
    state_nxt    = state;
    slot_cnt_nxt = slot_cnt;
    shift_nxt    = shift_reg;
    sym_idx_nxt  = o_SYM_IDX;
    sending      = (state == PRE) || (state == DATA);
    slot_end     = (slot_cnt == SLOT_LAST);
    in_window    = (32'(slot_cnt) >= POS_CYCLES) &&
                   (32'(slot_cnt) < POS_CYCLES + HIGH_CYCLES);
    sym_val      = (state == PRE) ? 1'b1 : shift_reg[DATA_BITS-1];

    case (state)
      IDLE: begin
        if (i_START) begin
          state_nxt = PRE;
          shift_nxt = i_DATA;
        end
      end
      PRE, DATA: begin
        slot_cnt_nxt = slot_end ? '0 : slot_cnt + CNT_W'(1);
        if (slot_end) begin
          if (state == DATA) shift_nxt = shift_reg << 1;
          // The index stays on the last symbol through FIN instead of running past the frame.
          if (o_SYM_IDX == FRAME_LAST) begin
            state_nxt = FIN;
          end else begin
            sym_idx_nxt = o_SYM_IDX + 7'(1);
            if (state == PRE && o_SYM_IDX == PRE_LAST) state_nxt = DATA;
          end
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (i_ABORT && state != IDLE) state_nxt = IDLE;
    if (state_nxt == IDLE) begin
      slot_cnt_nxt = '0;
      sym_idx_nxt  = '0;
    end

    busy_nxt = (state_nxt == PRE) || (state_nxt == DATA);
    done_nxt = (state_nxt == FIN);
    // Gating on busy_nxt truncates a pulse on abort and at the end of the final slot.
    rfin_nxt = sending && busy_nxt && in_window && sym_val;
  end

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state     <= IDLE;
      slot_cnt  <= '0;
      shift_reg <= '0;
      o_SYM_IDX <= '0;
      o_RFIN    <= 1'b0;
      o_BUSY    <= 1'b0;
      o_DONE    <= 1'b0;
    end else begin
      state     <= state_nxt;
      slot_cnt  <= slot_cnt_nxt;
      shift_reg <= shift_nxt;
      o_SYM_IDX <= sym_idx_nxt;
      o_RFIN    <= rfin_nxt;
      o_BUSY    <= busy_nxt;
      o_DONE    <= done_nxt;
    end
  end

endmodule
